// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin sharing of one single-word DRAM port between NUM_REQ requesters; DRAM_TIMEOUT_EN adds a WAIT abort after TIMEOUT cycles
module dram_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      srstn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      dram_en_rd,
  output logic                      dram_en_wr,
  output logic [ADDR_W-1:0]         addr_in,
  output logic [ADDR_W-1:0]         addr_out,
  output logic [DATA_W-1:0]         data_out,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      dram_valid
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_q;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt;
  logic          we_q;
`ifdef DRAM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif
  // first set request scanning upward from rr_ptr with wrap-around
  function automatic logic [PW-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [PW-1:0] p);
    int j;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(p) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (r[j]) pick = PW'(j);
    end
  endfunction
  assign win  = pick(req, rr_ptr);
  assign nxt  = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
  assign busy = (state == WAIT);
  // issue on a request in IDLE, retire on dram_valid (or timeout) in WAIT
  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_q      <= '0;
      we_q       <= 1'b0;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      dram_en_rd <= 1'b0;
      dram_en_wr <= 1'b0;
      addr_in    <= '0;
      addr_out   <= '0;
      data_out   <= '0;
`ifdef DRAM_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      ack        <= '0;
      err        <= 1'b0;
      dram_en_rd <= 1'b0;
      dram_en_wr <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state      <= WAIT;
          win_q      <= win;
          we_q       <= req_we[win];
          gnt        <= NUM_REQ'(1) << win;
          dram_en_rd <= !req_we[win];
          dram_en_wr <= req_we[win];
          if (req_we[win]) begin
            addr_out <= req_addr[win*ADDR_W +: ADDR_W];
            data_out <= req_wdata[win*DATA_W +: DATA_W];
          end else begin
            addr_in  <= req_addr[win*ADDR_W +: ADDR_W];
          end
`ifdef DRAM_TIMEOUT_EN
          cnt        <= '0;
`endif
        end
      end else if (dram_valid) begin
        state  <= IDLE;
        gnt    <= '0;
        ack    <= NUM_REQ'(1) << win_q;
        rr_ptr <= nxt;
        if (!we_q) rdata <= data_in;
      end
`ifdef DRAM_TIMEOUT_EN
      else if (cnt == CW'(TIMEOUT - 1)) begin
        state  <= IDLE;
        gnt    <= '0;
        ack    <= NUM_REQ'(1) << win_q;
        err    <= 1'b1;
        rdata  <= '0;
        rr_ptr <= nxt;
      end else begin
        cnt    <= cnt + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: table-driven cycle vectors plus reset and timeout sequences
module tb_dram_port_arbiter;
  localparam logic [17:0] A0 = 18'h00123;
  localparam logic [17:0] A1 = 18'h3FFFF;
  localparam logic [17:0] A2 = 18'h00ABC;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h0000_00A5;
  localparam logic [31:0] W2 = 32'h2222_2222;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] DD = 32'hD0D0_0024;
  logic        clk = 1'b0;
  logic        srstn = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  req_we = '0;
  logic [53:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  gnt, ack;
  logic [31:0] rdata, data_out;
  logic [31:0] data_in = '0;
  logic        err, busy, dram_en_rd, dram_en_wr;
  logic        dram_valid = 1'b0;
  logic [17:0] addr_in, addr_out;
  int ncmp = 0;
  int nerr = 0;
  assign req_addr  = {A2, A1, A0};
  assign req_wdata = {W2, W1, W0};
  dram_port_arbiter #(.NUM_REQ(3), .ADDR_W(18), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .srstn(srstn), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr), .addr_in(addr_in), .addr_out(addr_out),
    .data_out(data_out), .data_in(data_in), .dram_valid(dram_valid)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  req, we;
    logic        dv;
    logic [31:0] din;
    logic [2:0]  gnt, ack;
    logic        rd, wr, busy;
    logic [31:0] rdata;
    logic [17:0] ain, aout;
    logic [31:0] dout;
  } vec_t;
  vec_t tv [31];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_hs(input string nm, input logic [2:0] g, input logic [2:0] a, input logic b, input logic e);
    chk({nm, " gnt"}, 32'(gnt), 32'(g));
    chk({nm, " ack"}, 32'(ack), 32'(a));
    chk({nm, " busy"}, 32'(busy), 32'(b));
    chk({nm, " err"}, 32'(err), 32'(e));
  endtask
  initial begin
    tv[0]  = '{3'b001, 3'b000, 1'b0, 32'h0,  3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0, A0, 18'h0, 32'h0};
    tv[1]  = '{3'b001, 3'b000, 1'b0, 32'h0,  3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, A0, 18'h0, 32'h0};
    tv[2]  = '{3'b001, 3'b000, 1'b0, 32'h0,  3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, A0, 18'h0, 32'h0};
    tv[3]  = '{3'b001, 3'b000, 1'b1, DB,     3'b000, 3'b001, 1'b0, 1'b0, 1'b0, DB,    A0, 18'h0, 32'h0};
    tv[4]  = '{3'b000, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b0, 1'b0, DB,    A0, 18'h0, 32'h0};
    tv[5]  = '{3'b010, 3'b010, 1'b0, 32'h0,  3'b010, 3'b000, 1'b0, 1'b1, 1'b1, DB,    A0, A1, W1};
    tv[6]  = '{3'b010, 3'b010, 1'b1, 32'hFFFF_FFFF, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, DB, A0, A1, W1};
    tv[7]  = '{3'b000, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b0, 1'b0, DB,    A0, A1, W1};
    tv[8]  = '{3'b111, 3'b000, 1'b1, 32'hC0, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, DB,    A2, A1, W1};
    tv[9]  = '{3'b111, 3'b000, 1'b1, 32'hC1, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 32'hC1, A2, A1, W1};
    tv[10] = '{3'b111, 3'b000, 1'b1, 32'hC2, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 32'hC1, A0, A1, W1};
    tv[11] = '{3'b111, 3'b000, 1'b1, 32'hC3, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 32'hC3, A0, A1, W1};
    tv[12] = '{3'b111, 3'b000, 1'b1, 32'hC4, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 32'hC3, A1, A1, W1};
    tv[13] = '{3'b111, 3'b000, 1'b1, 32'hC5, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 32'hC5, A1, A1, W1};
    tv[14] = '{3'b111, 3'b000, 1'b1, 32'hC6, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 32'hC5, A2, A1, W1};
    tv[15] = '{3'b111, 3'b000, 1'b1, 32'hC7, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 32'hC7, A2, A1, W1};
    tv[16] = '{3'b111, 3'b000, 1'b1, 32'hC8, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 32'hC7, A0, A1, W1};
    tv[17] = '{3'b111, 3'b000, 1'b1, 32'hC9, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 32'hC9, A0, A1, W1};
    tv[18] = '{3'b111, 3'b000, 1'b1, 32'hCA, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 32'hC9, A1, A1, W1};
    tv[19] = '{3'b111, 3'b000, 1'b1, 32'hCB, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 32'hCB, A1, A1, W1};
    tv[20] = '{3'b000, 3'b000, 1'b1, 32'hCC, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'hCB, A1, A1, W1};
    tv[21] = '{3'b000, 3'b000, 1'b1, 32'hCD, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'hCB, A1, A1, W1};
    tv[22] = '{3'b100, 3'b000, 1'b0, 32'h0,  3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 32'hCB, A2, A1, W1};
    tv[23] = '{3'b000, 3'b100, 1'b0, 32'h0,  3'b100, 3'b000, 1'b0, 1'b0, 1'b1, 32'hCB, A2, A1, W1};
    tv[24] = '{3'b000, 3'b000, 1'b1, DD,     3'b000, 3'b100, 1'b0, 1'b0, 1'b0, DD,    A2, A1, W1};
    tv[25] = '{3'b000, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b0, 1'b0, DD,    A2, A1, W1};
    tv[26] = '{3'b011, 3'b000, 1'b1, 32'hE0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1, DD,    A0, A1, W1};
    tv[27] = '{3'b011, 3'b000, 1'b1, 32'hE1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 32'hE1, A0, A1, W1};
    tv[28] = '{3'b011, 3'b000, 1'b1, 32'hE2, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 32'hE1, A1, A1, W1};
    tv[29] = '{3'b000, 3'b000, 1'b1, 32'hE3, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 32'hE3, A1, A1, W1};
    tv[30] = '{3'b000, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'hE3, A1, A1, W1};
    repeat (2) @(posedge clk);
    #1;
    chk_hs("reset", 3'b000, 3'b000, 1'b0, 1'b0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset en_rd", 32'(dram_en_rd), 32'h0);
    chk("reset en_wr", 32'(dram_en_wr), 32'h0);
    chk("reset addr_in", 32'(addr_in), 32'h0);
    chk("reset data_out", data_out, 32'h0);
    #2 srstn = 1'b0;
    for (int r = 0; r < 31; r++) begin
      req = tv[r].req;
      req_we = tv[r].we;
      dram_valid = tv[r].dv;
      data_in = tv[r].din;
      step();
      chk_hs($sformatf("row%0d", r), tv[r].gnt, tv[r].ack, tv[r].busy, 1'b0);
      chk($sformatf("row%0d en_rd", r), 32'(dram_en_rd), 32'(tv[r].rd));
      chk($sformatf("row%0d en_wr", r), 32'(dram_en_wr), 32'(tv[r].wr));
      chk($sformatf("row%0d rdata", r), rdata, tv[r].rdata);
      chk($sformatf("row%0d addr_in", r), 32'(addr_in), 32'(tv[r].ain));
      chk($sformatf("row%0d addr_out", r), 32'(addr_out), 32'(tv[r].aout));
      chk($sformatf("row%0d data_out", r), data_out, tv[r].dout);
    end
    req = 3'b001;
    req_we = 3'b000;
    dram_valid = 1'b0;
    step();
    chk_hs("prereset", 3'b001, 3'b000, 1'b1, 1'b0);
    #2 srstn = 1'b1;
    #1;
    chk_hs("async reset", 3'b000, 3'b000, 1'b0, 1'b0);
    chk("async reset rdata", rdata, 32'h0);
    chk("async reset addr_in", 32'(addr_in), 32'h0);
    req = 3'b000;
    dram_valid = 1'b1;
    @(posedge clk);
    #3 srstn = 1'b0;
    repeat (3) begin
      step();
      chk_hs("post-reset valid", 3'b000, 3'b000, 1'b0, 1'b0);
    end
    req = 3'b111;
    data_in = 32'h5A5A_5A5A;
    step();
    chk_hs("rr after reset", 3'b001, 3'b000, 1'b1, 1'b0);
    step();
    chk_hs("rr after reset ack", 3'b000, 3'b001, 1'b0, 1'b0);
    chk("rr after reset rdata", rdata, 32'h5A5A_5A5A);
    req = 3'b000;
    step();
    chk_hs("idle again", 3'b000, 3'b000, 1'b0, 1'b0);
    req = 3'b001;
    dram_valid = 1'b0;
    step();
    chk_hs("to strobe", 3'b001, 3'b000, 1'b1, 1'b0);
    chk("to addr_in", 32'(addr_in), 32'(A0));
    req = 3'b000;
    repeat (3) begin
      step();
      chk_hs("to wait", 3'b001, 3'b000, 1'b1, 1'b0);
    end
    step();
`ifdef DRAM_TIMEOUT_EN
    chk_hs("timeout ack", 3'b000, 3'b001, 1'b0, 1'b1);
    chk("timeout rdata", rdata, 32'h0);
    step();
    chk_hs("timeout idle", 3'b000, 3'b000, 1'b0, 1'b0);
`else
    chk_hs("no timeout", 3'b001, 3'b000, 1'b1, 1'b0);
    repeat (6) step();
    chk_hs("no timeout late", 3'b001, 3'b000, 1'b1, 1'b0);
    dram_valid = 1'b1;
    data_in = 32'h0BAD_F00D;
    step();
    chk_hs("late valid ack", 3'b000, 3'b001, 1'b0, 1'b0);
    chk("late valid rdata", rdata, 32'h0BAD_F00D);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the accelerator's single DRAM port between NUM_REQ internal requesters: weight loader, feature-map loader and output writer.
- Serialises single-word read and write transactions onto dram_en_rd/addr_in/data_in and dram_en_wr/addr_out/data_out.
- Completion is signalled by dram_valid; read data and an ack pulse are returned to the granted requester.
- Sits between the lenet datapath engines and the DRAM pins.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 18: DRAM word address width.
- DATA_W, 32: DRAM data width.
- TIMEOUT, 255: WAIT cycles before abort. Used only with DRAM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- srstn  in  1  reset; asynchronous, active-high (asserted = 1); clears all state immediately.
- req  in  NUM_REQ  per-requester request; held high until ack.
- req_we  in  NUM_REQ  1 = write, 0 = read; qualified by req.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; same packing.
- gnt  out  NUM_REQ  one-hot grant, high from issue until completion.
- ack  out  NUM_REQ  one-cycle completion pulse to the winner.
- rdata  out  DATA_W  captured read data, valid in the ack cycle and held afterwards.
- err  out  1  high with ack when the transaction timed out.
- busy  out  1  high while state != IDLE.
- dram_en_rd  out  1  one-cycle read strobe.
- dram_en_wr  out  1  one-cycle write strobe.
- addr_in  out  ADDR_W  DRAM read address.
- addr_out  out  ADDR_W  DRAM write address.
- data_out  out  DATA_W  DRAM write data.
- data_in  in  DATA_W  DRAM read data, valid with dram_valid.
- dram_valid  in  1  DRAM completion for the outstanding read or write.

Behaviour:
- Reset values: all outputs 0; state = IDLE; round-robin pointer rr_ptr = 0.
- All outputs are registered.
- FSM states: IDLE, WAIT.
- IDLE:
  - If any req bit is set at edge k, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - During cycle k+1: gnt[winner] = 1; exactly one of dram_en_rd/dram_en_wr = 1 for that single cycle (per req_we[winner]); state = WAIT.
  - Read: addr_in <= req_addr[winner].
  - Write: addr_out <= req_addr[winner], data_out <= req_wdata[winner].
  - Address/data registers hold their value until the next grant of the same type.
- WAIT:
  - dram_valid is sampled every cycle, starting with the strobe cycle itself (zero-latency DRAM allowed).
  - On the edge where dram_valid = 1, the next cycle has: ack[winner] = 1 for one cycle; gnt = 0; rdata <= data_in (reads only, writes leave rdata unchanged); rr_ptr <= (winner+1) mod NUM_REQ; state = IDLE.
- Throughput: minimum 2 cycles per transaction. The ack cycle is an IDLE cycle, so a new request can be sampled at its end.
- Re-requests: a requester whose req is still high during its own ack cycle is treated as a new request. It competes at lowest priority because rr_ptr has advanced.
- Ignored inputs:
  - dram_valid in IDLE is ignored.
  - Changes to req, req_we, req_addr or req_wdata during WAIT are ignored; the latched transaction completes regardless.
  - A requester dropping req before ack is still acked.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 transactions.
- Reset mid-transaction: the outstanding transaction is dropped without ack, and a later dram_valid is ignored since the FSM is in IDLE.

Optional Feature:
- DRAM_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without dram_valid.
  - When it reaches TIMEOUT, the next cycle has: ack[winner] = 1, err = 1 (one cycle), rdata = 0, rr_ptr advanced, state = IDLE.
  - If dram_valid and timeout coincide, dram_valid wins and err = 0.
- Not defined: WAIT persists indefinitely; err is tied 0; no counter logic.

Test Plan:
- Read: req[0]=1, we=0, addr=18'h00123; dram_valid=1 with data_in=32'hDEADBEEF two cycles after strobe -> dram_en_rd pulse with addr_in=18'h00123; ack[0] pulse; rdata=32'hDEADBEEF; busy high 3 cycles.
- Write: req[1]=1, we=1, addr=18'h3FFFF, wdata=32'h0000_00A5; dram_valid in the strobe cycle -> dram_en_wr 1 cycle, addr_out=18'h3FFFF, data_out=32'h000000A5; ack[1] next cycle; rdata unchanged.
- Fairness: req=3'b111 held continuously, dram_valid tied 1 -> grants in order 0,1,2,0,1,2; each gnt one-hot; new strobe every 2 cycles.
- Ignored and dropped requests: dram_valid pulses while IDLE -> no ack. req[2] dropped mid-WAIT -> ack[2] still issued.
- Reset mid-WAIT: srstn=1 for 1 cycle mid-WAIT -> all outputs 0 immediately (asynchronous); later dram_valid produces no ack.
- Timeout (DRAM_TIMEOUT_EN, TIMEOUT=4): read issued, dram_valid never arrives -> ack with err=1 and rdata=0 after 4 WAIT cycles, then IDLE. Without the macro: busy stays high.
